frame_sched: RTL and testbench

Ping-pong frame-buffer scheduler for the camera → VGA → UART path. It tracks which of the two frame buffers the camera writes and which the VGA controller displays. Buffers swap only during vertical blanking, and only after the camera has completed a frame. Every FRAME_DIV-th swap it launches a UART transmission of the transmission buffer and locks that buffer against VGA writes until the transmitter finishes.

---
 rtl/frame_sched.sv | 162 ++++++++++++++++
 tb/tb_frame_sched.sv | 201 ++++++++++++++++++++
 2 files changed

// File: rtl/frame_sched.sv
// rtl/frame_sched.sv - ping-pong frame buffer scheduler with periodic UART launch (option: FRAME_SCHED_TIMEOUT_EN)
module frame_sched #(
  parameter int FRAME_DIV = 4,
  parameter int TIMEOUT   = 1023
) (
  input  logic       dclk,
  input  logic       clr,
  input  logic       cam_frame_done,
  input  logic       vsync,
  input  logic       tx_busy,
  output logic       wr_sel,
  output logic       select,
  output logic       tx_start,
  output logic       tmem_lock,
  output logic [7:0] frames_dropped,
  output logic [7:0] tx_skips,
  output logic [1:0] sched_state
);

  typedef enum logic [1:0] {ST_IDLE = 2'd0, ST_PEND = 2'd1, ST_SWAP = 2'd2} state_t;
  typedef enum logic [1:0] {TX_IDLE = 2'd0, TX_START = 2'd1, TX_WAIT = 2'd2, TX_RUN = 2'd3} tx_state_t;

  localparam logic [7:0] DIV_LAST = 8'(FRAME_DIV - 1);

  state_t    r_state, w_state_next;
  tx_state_t r_tx_state, w_tx_next;
  logic       r_vsync_q;
  logic       r_done_pend;
  logic       r_wr_sel, r_select;
  logic [7:0] r_swap_cnt;
  logic [7:0] r_frames_dropped, r_tx_skips;
  logic       r_tx_start, r_tmem_lock;
  logic       w_vb_edge, w_swap, w_launch, w_drop, w_set_pend;
  logic       w_skip_launch, w_timeout;
  logic [1:0] w_skip_inc;
  logic [8:0] w_skip_sum;

  assign w_vb_edge     = r_vsync_q & ~vsync;
  assign w_swap        = (r_state == ST_SWAP);
  assign w_launch      = w_swap && (r_swap_cnt == DIV_LAST);
  assign w_skip_launch = w_launch && (r_tx_state != TX_IDLE);
  assign w_skip_inc    = {1'b0, w_skip_launch} + {1'b0, w_timeout};
  assign w_skip_sum    = {1'b0, r_tx_skips} + {7'd0, w_skip_inc};

  assign wr_sel         = r_wr_sel;
  assign select         = r_select;
  assign tx_start       = r_tx_start;
  assign tmem_lock      = r_tmem_lock;
  assign frames_dropped = r_frames_dropped;
  assign tx_skips       = r_tx_skips;
  assign sched_state    = r_state;

  // Delayed vsync for falling-edge (start of vblank) detection
  always_ff @(posedge dclk) begin
    if (clr) r_vsync_q <= 1'b1;
    else     r_vsync_q <= vsync;
  end

  // Main FSM state register
  always_ff @(posedge dclk) begin
    if (clr) r_state <= ST_IDLE;
    else     r_state <= w_state_next;
  end

  // Main FSM next state; a frame finishing alongside the swap is carried into PEND
  always_comb begin
    w_state_next = r_state;
    w_drop       = 1'b0;
    w_set_pend   = 1'b0;
    case (r_state)
      ST_IDLE: if (cam_frame_done) w_state_next = ST_PEND;
      ST_PEND: begin
        if (w_vb_edge) begin
          w_state_next = ST_SWAP;
          w_set_pend   = cam_frame_done;
        end else if (cam_frame_done) begin
          w_drop = 1'b1;
        end
      end
      ST_SWAP: w_state_next = (r_done_pend || cam_frame_done) ? ST_PEND : ST_IDLE;
      default: w_state_next = ST_IDLE;
    endcase
  end

  // Buffer selects, swap divider, pending-frame flag and drop counter
  always_ff @(posedge dclk) begin
    if (clr) begin
      r_wr_sel         <= 1'b0;
      r_select         <= 1'b1;
      r_swap_cnt       <= 8'd0;
      r_done_pend      <= 1'b0;
      r_frames_dropped <= 8'd0;
    end else begin
      if (w_swap) begin
        r_wr_sel    <= ~r_wr_sel;
        r_select    <= r_wr_sel;
        r_swap_cnt  <= (r_swap_cnt == DIV_LAST) ? 8'd0 : r_swap_cnt + 8'd1;
        r_done_pend <= 1'b0;
      end else if (w_set_pend) begin
        r_done_pend <= 1'b1;
      end
      if (w_drop && r_frames_dropped != 8'hFF)
        r_frames_dropped <= r_frames_dropped + 8'd1;
    end
  end

`ifdef FRAME_SCHED_TIMEOUT_EN
  localparam int CW = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT + 1);
  localparam logic [CW-1:0] TIMEOUT_V = CW'(TIMEOUT);
  logic [CW-1:0] r_wait_cnt;

  // Cycles spent in TX_WAIT without seeing the transmitter go busy
  always_ff @(posedge dclk) begin
    if (clr || r_tx_state != TX_WAIT) r_wait_cnt <= '0;
    else                              r_wait_cnt <= r_wait_cnt + 1'b1;
  end
`endif

  // TX FSM next state
  always_comb begin
    w_tx_next = r_tx_state;
`ifdef FRAME_SCHED_TIMEOUT_EN
    w_timeout = 1'b0;
`endif
    case (r_tx_state)
      TX_IDLE:  if (w_launch) w_tx_next = TX_START;
      TX_START: w_tx_next = TX_WAIT;
      TX_WAIT: begin
        if (tx_busy) begin
          w_tx_next = TX_RUN;
`ifdef FRAME_SCHED_TIMEOUT_EN
        end else if (r_wait_cnt == TIMEOUT_V) begin
          w_tx_next = TX_IDLE;
          w_timeout = 1'b1;
`endif
        end
      end
      TX_RUN:   if (!tx_busy) w_tx_next = TX_IDLE;
      default:  w_tx_next = TX_IDLE;
    endcase
  end

`ifndef FRAME_SCHED_TIMEOUT_EN
  assign w_timeout = 1'b0;
`endif

  // TX FSM state plus flopped strobe/lock derived from the next state
  always_ff @(posedge dclk) begin
    if (clr) begin
      r_tx_state  <= TX_IDLE;
      r_tx_start  <= 1'b0;
      r_tmem_lock <= 1'b0;
      r_tx_skips  <= 8'd0;
    end else begin
      r_tx_state  <= w_tx_next;
      r_tx_start  <= (w_tx_next == TX_START);
      r_tmem_lock <= (w_tx_next != TX_IDLE);
      r_tx_skips  <= w_skip_sum[8] ? 8'hFF : w_skip_sum[7:0];
    end
  end

endmodule

// File: tb/tb_frame_sched.sv
// tb/tb_frame_sched.sv - randomized check of frame_sched (FRAME_DIV 4 and 1) against a behavioural model
module tb_frame_sched;

  localparam int TO = 16;

  logic dclk = 1'b0;
  always #20 dclk = ~dclk;

  logic       clr, done, vsync;
  logic       busy [2];
  logic       wr_sel_o [2];
  logic       select_o [2];
  logic       tx_start_o [2];
  logic       lock_o [2];
  logic [7:0] drop_o [2];
  logic [7:0] skip_o [2];
  logic [1:0] st_o [2];

  int n_checks = 0;
  int n_errors = 0;

  frame_sched #(.FRAME_DIV(4), .TIMEOUT(TO)) u_div4 (
    .dclk(dclk), .clr(clr), .cam_frame_done(done), .vsync(vsync), .tx_busy(busy[0]),
    .wr_sel(wr_sel_o[0]), .select(select_o[0]), .tx_start(tx_start_o[0]), .tmem_lock(lock_o[0]),
    .frames_dropped(drop_o[0]), .tx_skips(skip_o[0]), .sched_state(st_o[0])
  );

  frame_sched #(.FRAME_DIV(1), .TIMEOUT(TO)) u_div1 (
    .dclk(dclk), .clr(clr), .cam_frame_done(done), .vsync(vsync), .tx_busy(busy[1]),
    .wr_sel(wr_sel_o[1]), .select(select_o[1]), .tx_start(tx_start_o[1]), .tmem_lock(lock_o[1]),
    .frames_dropped(drop_o[1]), .tx_skips(skip_o[1]), .sched_state(st_o[1])
  );

  // Reference model: phase 0 idle / 1 frame waiting / 2 swapping; tx 0 none / 1 starting / 2 awaiting busy / 3 sending
  int m_state [2];
  int m_extra [2];
  int m_swaps [2];
  int m_drop  [2];
  int m_skip  [2];
  int m_tx    [2];
  int m_wcnt  [2];
  int bd      [2];
  int bl      [2];
  int prev_vs;

  function automatic int div_of(input int k);
    return (k == 0) ? 4 : 1;
  endfunction

  function automatic int sat_inc(input int v);
    return (v < 255) ? v + 1 : 255;
  endfunction

  task automatic chk(input string tag, input int got, input int exp);
    n_checks++;
    if (got != exp) begin
      n_errors++;
      $display("FAIL %s got %0d expected %0d at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    for (int k = 0; k < 2; k++) begin
      m_state[k] = 0; m_extra[k] = 0; m_swaps[k] = 0; m_drop[k] = 0;
      m_skip[k] = 0;  m_tx[k] = 0;    m_wcnt[k] = 0;  bd[k] = 0; bl[k] = 0;
    end
    prev_vs = 1;
  endtask

  task automatic check_all();
    for (int k = 0; k < 2; k++) begin
      chk($sformatf("wr_sel[%0d]", k),    int'(wr_sel_o[k]),   m_swaps[k] % 2);
      chk($sformatf("select[%0d]", k),    int'(select_o[k]),   1 - (m_swaps[k] % 2));
      chk($sformatf("tx_start[%0d]", k),  int'(tx_start_o[k]), (m_tx[k] == 1) ? 1 : 0);
      chk($sformatf("tmem_lock[%0d]", k), int'(lock_o[k]),     (m_tx[k] != 0) ? 1 : 0);
      chk($sformatf("dropped[%0d]", k),   int'(drop_o[k]),     m_drop[k]);
      chk($sformatf("skips[%0d]", k),     int'(skip_o[k]),     m_skip[k]);
      chk($sformatf("state[%0d]", k),     int'(st_o[k]),       m_state[k]);
    end
  endtask

  task automatic model_update(input logic d, input logic v, input logic c);
    int  old_tx;
    bit  launch;
    bit  edge_v;
    if (c) begin
      model_reset();
      return;
    end
    edge_v = (prev_vs == 1) && !v;
    for (int k = 0; k < 2; k++) begin
      launch = 1'b0;
      old_tx = m_tx[k];
      case (m_state[k])
        0: if (d) m_state[k] = 1;
        1: begin
          if (edge_v) begin
            m_state[k] = 2;
            if (d) m_extra[k] = 1;
          end else if (d) begin
            m_drop[k] = sat_inc(m_drop[k]);
          end
        end
        default: begin
          m_swaps[k]++;
          launch     = (m_swaps[k] % div_of(k)) == 0;
          m_state[k] = (m_extra[k] != 0 || d) ? 1 : 0;
          m_extra[k] = 0;
        end
      endcase
      case (old_tx)
        0: if (launch) begin
          m_tx[k] = 1;
          bd[k]   = int'($urandom_range(1, 5));
          bl[k]   = ($urandom_range(0, 7) == 0) ? 0 : int'($urandom_range(3, 60));
        end
        1: begin m_tx[k] = 2; m_wcnt[k] = 0; end
        2: begin
          if (busy[k]) m_tx[k] = 3;
`ifdef FRAME_SCHED_TIMEOUT_EN
          else if (m_wcnt[k] == TO) begin m_tx[k] = 0; m_skip[k] = sat_inc(m_skip[k]); end
          else m_wcnt[k]++;
`endif
        end
        default: if (!busy[k]) m_tx[k] = 0;
      endcase
      if (launch && old_tx != 0) m_skip[k] = sat_inc(m_skip[k]);
    end
    prev_vs = v ? 1 : 0;
  endtask

  // One cycle: check outputs from the last edge, drive new inputs, advance the model
  task automatic step(input logic d, input logic v, input logic c);
    @(negedge dclk);
    check_all();
    for (int k = 0; k < 2; k++) begin
      if (bd[k] > 0)      begin bd[k]--; busy[k] = 1'b0; end
      else if (bl[k] > 0) begin bl[k]--; busy[k] = 1'b1; end
      else                busy[k] = 1'b0;
    end
    done = d; vsync = v; clr = c;
    model_update(d, v, c);
  endtask

  initial begin
    int vcnt;
    bit vlow;
    clr = 1'b1; done = 1'b0; vsync = 1'b1; busy[0] = 1'b0; busy[1] = 1'b0;
    model_reset();
    repeat (2) @(posedge dclk);

    // first swap timing: done, then vsync falls 100 cycles later
    step(0, 1, 0);
    step(1, 1, 0);
    repeat (100) step(0, 1, 0);
    step(0, 0, 0);
    step(0, 0, 0);
    chk("first_swap_state", int'(st_o[0]), 2);
    step(0, 0, 0);
    chk("first_swap_wr_sel", int'(wr_sel_o[0]), 1);
    chk("first_swap_select", int'(select_o[0]), 0);
    chk("first_swap_idle", int'(st_o[0]), 0);
    repeat (3) step(0, 1, 0);

    // three frames before a vblank: two dropped, one swap
    step(1, 1, 0); step(0, 1, 0);
    step(1, 1, 0); step(0, 1, 0);
    step(1, 1, 0); step(0, 1, 0); step(0, 1, 0);
    chk("three_frames_dropped", int'(drop_o[0]), 2);
    step(0, 0, 0); repeat (3) step(0, 1, 0);
    chk("three_frames_wr_sel", int'(wr_sel_o[0]), 0);

    // frame done coincident with vblank edge in PEND
    step(1, 1, 0); step(0, 1, 0);
    step(1, 0, 0); step(0, 1, 0); step(0, 1, 0);
    chk("coincident_state", int'(st_o[0]), 1);
    chk("coincident_dropped", int'(drop_o[0]), 2);
    chk("coincident_wr_sel", int'(wr_sel_o[0]), 1);
    step(0, 0, 0); step(0, 1, 0); step(0, 1, 0);
    chk("fourth_swap_tx_start", int'(tx_start_o[0]), 1);
    chk("fourth_swap_lock", int'(lock_o[0]), 1);
    repeat (80) step(0, 1, 0);

    // randomized frames, vblanks, transmitter timing and occasional clear
    vcnt = 20; vlow = 1'b0;
    for (int cyc = 0; cyc < 6000; cyc++) begin
      if (vcnt == 0) begin
        vlow = ~vlow;
        vcnt = vlow ? int'($urandom_range(2, 4)) : int'($urandom_range(8, 60));
      end else begin
        vcnt--;
      end
      step(($urandom_range(0, 14) == 0), !vlow, ($urandom_range(0, 699) == 0));
    end
    step(0, 1, 0);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
